// File: rtl/mem_access_stage.sv
// MEM stage of the cqu_mips pipeline: issues loads/stores over a req/ack
// data-memory bus, extends load data and registers the MEM/WB outputs.
module mem_access_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_write_reg,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_load_unsigned,
  input  logic        wb_stall,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic [31:0] final_result,
  output logic [4:0]  write_reg_out,
  output logic        reg_write_final,
  output logic        mem_to_reg_final,
  output logic        addr_error,
  output logic        bus_error,
  output logic [31:0] bad_vaddr
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;

  logic [31:0]   addr_q, wdata_q, hold_q;
  logic [1:0]    size_q;
  logic          uns_q, regw_q, store_q;
  logic [4:0]    wreg_q;
  logic [3:0]    be_q;
  logic [CW-1:0] tcnt;

  logic        mem_op, misaligned, timeout_hit, capture;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;

  // Pick the addressed byte/half of a bus word and extend it to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] a,
                                           input logic [1:0] sz, input logic u);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = a[1] ? d[31:16] : d[15:0];
    case (sz)
      2'b00:   load_ext = u ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   load_ext = u ? {16'h0, h} : {{16{h[15]}}, h};
      default: load_ext = d;
    endcase
  endfunction

  // Decode of the incoming EX/MEM op: alignment, byte enables and store data.
  always_comb begin
    mem_op     = ex_mem_read | ex_mem_write;
    misaligned = ((ex_mem_size == 2'b01) && ex_alu_result[0]) ||
                 (ex_mem_size[1] && (ex_alu_result[1:0] != 2'b00));
    capture    = (state == IDLE) && !wb_stall && ex_valid && mem_op && !misaligned;
    be_c       = 4'b1111;
    wdata_c    = ex_store_data;
    if (ex_mem_write) begin
      case (ex_mem_size)
        2'b00: begin
          be_c    = 4'b0001 << ex_alu_result[1:0];
          wdata_c = {4{ex_store_data[7:0]}};
        end
        2'b01: begin
          be_c    = 4'b0011 << {ex_alu_result[1], 1'b0};
          wdata_c = {2{ex_store_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  // Next-state logic, bus outputs and upstream stall.
  always_comb begin
    state_nxt   = state;
    timeout_hit = (state == ACCESS) && !dmem_ack && (tcnt == TC_LAST);
    mem_stall   = 1'b0;
    case (state)
      IDLE: begin
        // The slot is held while its memory op is in flight and released on
        // the cycle it retires, so a capture cycle counts as a stall cycle.
        mem_stall = wb_stall | capture;
        if (capture) state_nxt = ACCESS;
      end
      ACCESS: begin
        mem_stall = !((dmem_ack && !wb_stall) || timeout_hit);
        if (dmem_ack)         state_nxt = wb_stall ? DONE : IDLE;
        else if (timeout_hit) state_nxt = IDLE;
      end
      DONE: begin
        mem_stall = wb_stall;
        if (!wb_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign dmem_req   = (state == ACCESS);
  assign dmem_we    = (state == ACCESS) && store_q;
  assign dmem_addr  = {addr_q[31:2], 2'b00};
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

  // FSM state, captured access fields, ack hold register and timeout counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      hold_q  <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      regw_q  <= 1'b0;
      store_q <= 1'b0;
      wreg_q  <= '0;
      be_q    <= '0;
      tcnt    <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        addr_q  <= ex_alu_result;
        wdata_q <= wdata_c;
        size_q  <= ex_mem_size;
        uns_q   <= ex_load_unsigned;
        regw_q  <= ex_reg_write;
        store_q <= ex_mem_write;
        wreg_q  <= ex_write_reg;
        be_q    <= be_c;
      end
      if ((state == ACCESS) && dmem_ack && wb_stall) hold_q <= dmem_rdata;
      if ((state == ACCESS) && (state_nxt == ACCESS)) tcnt <= tcnt + 1'b1;
      else                                            tcnt <= '0;
    end
  end

  // MEM/WB register: retire, bubble or hold, plus fault pulses and address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      final_result     <= '0;
      write_reg_out    <= '0;
      reg_write_final  <= 1'b0;
      mem_to_reg_final <= 1'b0;
      addr_error       <= 1'b0;
      bus_error        <= 1'b0;
      bad_vaddr        <= '0;
    end else begin
      addr_error <= 1'b0;
      bus_error  <= 1'b0;
      case (state)
        IDLE: if (!wb_stall) begin
          reg_write_final  <= 1'b0;
          mem_to_reg_final <= 1'b0;
          if (ex_valid && !mem_op) begin
            final_result    <= ex_alu_result;
            write_reg_out   <= ex_write_reg;
            reg_write_final <= ex_reg_write;
          end else if (ex_valid && misaligned) begin
            write_reg_out <= ex_write_reg;
            addr_error    <= 1'b1;
            bad_vaddr     <= ex_alu_result;
          end
        end
        ACCESS: begin
          if (dmem_ack) begin
            if (!wb_stall) begin
              write_reg_out    <= wreg_q;
              reg_write_final  <= store_q ? 1'b0 : regw_q;
              mem_to_reg_final <= !store_q;
              if (!store_q) final_result <= load_ext(dmem_rdata, addr_q[1:0], size_q, uns_q);
            end
          end else begin
            if (timeout_hit) begin
              bus_error <= 1'b1;
              bad_vaddr <= addr_q;
            end
            if (!wb_stall) begin
              reg_write_final  <= 1'b0;
              mem_to_reg_final <= 1'b0;
            end
          end
        end
        DONE: if (!wb_stall) begin
          write_reg_out    <= wreg_q;
          reg_write_final  <= store_q ? 1'b0 : regw_q;
          mem_to_reg_final <= !store_q;
          if (!store_q) final_result <= load_ext(hold_q, addr_q[1:0], size_q, uns_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu_result = '0;
  logic [31:0] ex_store_data = '0;
  logic [4:0]  ex_write_reg = '0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic [1:0]  ex_mem_size = '0;
  logic        ex_load_unsigned = 1'b0;
  logic        wb_stall = 1'b0;
  logic        mem_stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic [31:0] final_result;
  logic [4:0]  write_reg_out;
  logic        reg_write_final, mem_to_reg_final;
  logic        addr_error, bus_error;
  logic [31:0] bad_vaddr;

  int pass_cnt = 0;
  int total    = 0;

  mem_access_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
    .ex_write_reg(ex_write_reg), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_mem_size(ex_mem_size), .ex_load_unsigned(ex_load_unsigned),
    .wb_stall(wb_stall), .mem_stall(mem_stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .final_result(final_result), .write_reg_out(write_reg_out),
    .reg_write_final(reg_write_final), .mem_to_reg_final(mem_to_reg_final),
    .addr_error(addr_error), .bus_error(bus_error), .bad_vaddr(bad_vaddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // One memory op: capture, `waits` cycles without ack, then ack with rdata.
  task automatic run_mem(input string tag, input logic [31:0] addr, input logic [1:0] size,
                         input logic uns, input logic st, input logic [31:0] sdata,
                         input int waits, input logic [31:0] rdata, input logic [3:0] exp_be,
                         input logic [31:0] exp_wdata, input logic [31:0] exp_res,
                         input int exp_stall);
    int stalls;
    stalls = 0;
    ex_valid = 1'b1; ex_alu_result = addr; ex_store_data = sdata; ex_write_reg = 5'd9;
    ex_reg_write = 1'b1; ex_mem_read = !st; ex_mem_write = st; ex_mem_size = size;
    ex_load_unsigned = uns;
    #1;
    if (mem_stall) stalls++;
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    chk({tag, "_req"}, 32'(dmem_req), 32'd1);
    chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
    chk({tag, "_be"}, 32'(dmem_be), 32'(exp_be));
    chk({tag, "_we"}, 32'(dmem_we), 32'(st));
    if (st) chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
    for (int i = 0; i < waits; i++) begin
      if (mem_stall) stalls++;
      step();
    end
    dmem_ack = 1'b1; dmem_rdata = rdata;
    #1;
    if (mem_stall) stalls++;
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'h0BAD_0BAD;
    chk({tag, "_stalls"}, 32'(stalls), 32'(exp_stall));
    chk({tag, "_req_off"}, 32'(dmem_req), 32'd0);
    chk({tag, "_rwf"}, 32'(reg_write_final), st ? 32'd0 : 32'd1);
    chk({tag, "_m2r"}, 32'(mem_to_reg_final), st ? 32'd0 : 32'd1);
    chk({tag, "_berr"}, 32'(bus_error), 32'd0);
    if (!st) begin
      chk({tag, "_result"}, final_result, exp_res);
      chk({tag, "_wreg"}, 32'(write_reg_out), 32'd9);
    end
  endtask

  initial begin
    int cnt;
    // Reset state
    step();
    chk("rst_final", final_result, 32'h0);
    chk("rst_rwf", 32'(reg_write_final), 32'd0);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(mem_stall), 32'd0);
    chk("rst_bad", bad_vaddr, 32'h0);
    chk("rst_errs", 32'({addr_error, bus_error}), 32'd0);
    reset = 1'b0;
    step();

    // ALU op: one-cycle latency
    ex_valid = 1'b1; ex_alu_result = 32'h1234; ex_write_reg = 5'd5; ex_reg_write = 1'b1;
    #1;
    chk("alu_stall", 32'(mem_stall), 32'd0);
    step();
    chk("alu_final", final_result, 32'h1234);
    chk("alu_wreg", 32'(write_reg_out), 32'd5);
    chk("alu_rwf", 32'(reg_write_final), 32'd1);
    chk("alu_m2r", 32'(mem_to_reg_final), 32'd0);
    ex_valid = 1'b0;
    step();
    chk("bubble_rwf", 32'(reg_write_final), 32'd0);
    chk("bubble_final", final_result, 32'h1234);

    // Write-back stall in IDLE: nothing accepted, MEM/WB holds
    wb_stall = 1'b1; ex_valid = 1'b1; ex_alu_result = 32'h77; ex_write_reg = 5'd6;
    #1;
    chk("wbs_idle_stall", 32'(mem_stall), 32'd1);
    step();
    chk("wbs_idle_hold", final_result, 32'h1234);
    chk("wbs_idle_rwf", 32'(reg_write_final), 32'd0);
    wb_stall = 1'b0;
    #1;
    chk("wbs_idle_rel", 32'(mem_stall), 32'd0);
    step();
    chk("wbs_idle_acc", final_result, 32'h77);
    chk("wbs_idle_wreg", 32'(write_reg_out), 32'd6);
    ex_valid = 1'b0;

    // Ack outside ACCESS is ignored
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    step();
    dmem_ack = 1'b0;
    chk("stray_ack_req", 32'(dmem_req), 32'd0);
    chk("stray_ack_final", final_result, 32'h77);
    chk("stray_ack_rwf", 32'(reg_write_final), 32'd0);

    // Loads
    run_mem("lb_s", 32'h103, 2'b00, 1'b0, 1'b0, 32'h0, 3, 32'h80FF_7F01, 4'b1111, 32'h0,
            32'hFFFF_FF80, 4);
    run_mem("lbu", 32'h103, 2'b00, 1'b1, 1'b0, 32'h0, 3, 32'h80FF_7F01, 4'b1111, 32'h0,
            32'h0000_0080, 4);
    run_mem("lb_l1", 32'h101, 2'b00, 1'b0, 1'b0, 32'h0, 0, 32'h80FF_7F01, 4'b1111, 32'h0,
            32'h0000_007F, 1);
    run_mem("lh_s", 32'h102, 2'b01, 1'b0, 1'b0, 32'h0, 1, 32'h80FF_7F01, 4'b1111, 32'h0,
            32'hFFFF_80FF, 2);
    run_mem("lhu", 32'h102, 2'b01, 1'b1, 1'b0, 32'h0, 0, 32'h80FF_7F01, 4'b1111, 32'h0,
            32'h0000_80FF, 1);
    run_mem("lw_ackto", 32'h108, 2'b10, 1'b0, 1'b0, 32'h0, 15, 32'h1234_5678, 4'b1111, 32'h0,
            32'h1234_5678, 16);

    // Stores
    run_mem("sh", 32'h202, 2'b01, 1'b0, 1'b1, 32'h0000_ABCD, 0, 32'h0, 4'b1100,
            32'hABCD_ABCD, 32'h0, 1);
    run_mem("sb", 32'h201, 2'b00, 1'b0, 1'b1, 32'h1234_565A, 2, 32'h0, 4'b0010,
            32'h5A5A_5A5A, 32'h0, 3);
    run_mem("sw11", 32'h20C, 2'b11, 1'b0, 1'b1, 32'hCAFE_F00D, 0, 32'h0, 4'b1111,
            32'hCAFE_F00D, 32'h0, 1);

    // Misaligned word load
    ex_valid = 1'b1; ex_alu_result = 32'h106; ex_write_reg = 5'd4; ex_reg_write = 1'b1;
    ex_mem_read = 1'b1; ex_mem_size = 2'b10;
    #1;
    chk("mis_stall", 32'(mem_stall), 32'd0);
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_aerr", 32'(addr_error), 32'd1);
    chk("mis_bad", bad_vaddr, 32'h106);
    chk("mis_rwf", 32'(reg_write_final), 32'd0);
    step();
    chk("mis_pulse", 32'(addr_error), 32'd0);
    chk("mis_bad_hold", bad_vaddr, 32'h106);

    // Timeout with no ack
    ex_valid = 1'b1; ex_alu_result = 32'h300; ex_mem_read = 1'b1; ex_mem_size = 2'b10;
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    cnt = 0;
    while (dmem_req && cnt < 40) begin
      cnt++;
      step();
    end
    chk("to_req_cycles", 32'(cnt), 32'd16);
    chk("to_berr", 32'(bus_error), 32'd1);
    chk("to_stall", 32'(mem_stall), 32'd0);
    chk("to_bad", bad_vaddr, 32'h300);
    chk("to_rwf", 32'(reg_write_final), 32'd0);
    step();
    chk("to_pulse", 32'(bus_error), 32'd0);

    // Ack while write-back stalled: hold in DONE, retire when stall falls
    ex_valid = 1'b1; ex_alu_result = 32'h55; ex_write_reg = 5'd3; ex_reg_write = 1'b1;
    step();
    ex_alu_result = 32'h500; ex_write_reg = 5'd12; ex_mem_read = 1'b1; ex_mem_size = 2'b10;
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF; wb_stall = 1'b1;
    #1;
    chk("done_ack_stall", 32'(mem_stall), 32'd1);
    step();
    dmem_ack = 1'b0; dmem_rdata = 32'h1111_1111;
    chk("done_req", 32'(dmem_req), 32'd0);
    chk("done_stall", 32'(mem_stall), 32'd1);
    chk("done_hold", final_result, 32'h55);
    chk("done_hold_rwf", 32'(reg_write_final), 32'd0);
    step();
    chk("done_hold2", final_result, 32'h55);
    wb_stall = 1'b0;
    #1;
    chk("done_rel", 32'(mem_stall), 32'd0);
    step();
    chk("done_result", final_result, 32'hDEAD_BEEF);
    chk("done_rwf", 32'(reg_write_final), 32'd1);
    chk("done_m2r", 32'(mem_to_reg_final), 32'd1);
    chk("done_wreg", 32'(write_reg_out), 32'd12);

    // Reset in the middle of an access
    ex_valid = 1'b1; ex_alu_result = 32'h400; ex_mem_read = 1'b1; ex_mem_size = 2'b10;
    step();
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    chk("rma_req_on", 32'(dmem_req), 32'd1);
    step();
    #1;
    reset = 1'b1;
    #1;
    chk("rma_req_off", 32'(dmem_req), 32'd0);
    chk("rma_final", final_result, 32'h0);
    chk("rma_stall", 32'(mem_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    dmem_ack = 1'b1; dmem_rdata = 32'hABAB_ABAB;
    step();
    dmem_ack = 1'b0;
    chk("rma_no_req", 32'(dmem_req), 32'd0);
    chk("rma_no_retire", 32'(reg_write_final), 32'd0);
    chk("rma_final2", final_result, 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
